// File: rtl/pipe_spawner.sv
// Pipe obstacle generator: 4-slot circular buffer of pipes, spawned/scrolled/retired on frame ticks.
// Slots, count, full and pass_pulse update one cycle after the tick edge; read port is combinational; tick is never stalled.
module pipe_spawner #(
  parameter int SCREEN_W = 640,
  parameter int SPEED    = 2,
  parameter int SPACING  = 90,
  parameter int GAP_MIN  = 80,
  parameter int PIPE_W   = 52,
  parameter int BIRD_X   = 160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       run,
  input  logic       clear,
  input  logic [6:0] rand_in,
  input  logic [1:0] rd_idx,
  output logic       rd_valid,
  output logic [9:0] rd_x,
  output logic [8:0] rd_gap,
  output logic       pass_pulse,
  output logic [2:0] count,
  output logic       full
);
  localparam int CW = (SPACING > 1) ? $clog2(SPACING) : 1;

  if (GAP_MIN + 127 > 511) begin : g_gap_check
    $error("GAP_MIN + 127 does not fit in the 9-bit gap field");
  end

  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

  state_t        state_q, state_d;
  logic [3:0]    valid_q, valid_d;
  logic [9:0]    x_q   [4];
  logic [9:0]    x_d   [4];
  logic [8:0]    gap_q [4];
  logic [8:0]    gap_d [4];
  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] spawn_cnt_q, spawn_cnt_d;
  logic          pass_d;
  logic          step;
  logic          load_cnt;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (run)  state_d = RUN;
        RUN:     if (!run) state_d = FROZEN;
        FROZEN:  if (run)  state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // A tick only acts when RUN is the current state; a same-edge run drop still honours it.
  always_comb begin
    step     = (state_q == RUN) && tick && !clear;
    load_cnt = (state_q == IDLE) && (state_d == RUN);
  end

  always_comb begin
    valid_d     = valid_q;
    x_d         = x_q;
    gap_d       = gap_q;
    wr_ptr_d    = wr_ptr_q;
    spawn_cnt_d = spawn_cnt_q;
    pass_d      = 1'b0;
    if (clear) begin
      valid_d     = '0;
      wr_ptr_d    = '0;
      spawn_cnt_d = '0;
    end else if (step) begin
      for (int i = 0; i < 4; i++) begin
        if (valid_q[i]) begin
          if ({1'b0, x_q[i]} < 11'(SPEED)) begin
            valid_d[i] = 1'b0;
          end else begin
            x_d[i] = x_q[i] - 10'(SPEED);
            if ((({1'b0, x_q[i]} + 11'(PIPE_W)) > 11'(BIRD_X)) &&
                (({1'b0, x_d[i]} + 11'(PIPE_W)) <= 11'(BIRD_X)))
              pass_d = 1'b1;
          end
        end
      end
      // Retirement above is already folded into valid_d, so a retiring slot counts as free.
      if (spawn_cnt_q == '0) begin
        spawn_cnt_d = CW'(SPACING - 1);
        if (!valid_d[wr_ptr_q]) begin
          valid_d[wr_ptr_q] = 1'b1;
          x_d[wr_ptr_q]     = 10'(SCREEN_W);
          gap_d[wr_ptr_q]   = 9'(GAP_MIN) + {2'b00, rand_in};
          wr_ptr_d          = wr_ptr_q + 2'd1;
        end
      end else begin
        spawn_cnt_d = spawn_cnt_q - CW'(1);
      end
    end else if (load_cnt) begin
      spawn_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      wr_ptr_q    <= '0;
      spawn_cnt_q <= '0;
      pass_pulse  <= 1'b0;
      count       <= '0;
      full        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_q[i]   <= '0;
        gap_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      x_q         <= x_d;
      gap_q       <= gap_d;
      wr_ptr_q    <= wr_ptr_d;
      spawn_cnt_q <= spawn_cnt_d;
      pass_pulse  <= pass_d;
      count       <= 3'($countones(valid_d));
      full        <= &valid_d;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_x     = x_q[rd_idx];
  assign rd_gap   = gap_q[rd_idx];

endmodule

// File: tb/tb_pipe_spawner.sv
// Bench for pipe_spawner: three instances (SPACING 90/40/1) checked every cycle against a behavioural pipe-list model.
`timescale 1ns/1ps
module tb_pipe_spawner;
  localparam int SCREEN_W = 640;
  localparam int SPEED    = 2;
  localparam int GAP_MIN  = 80;
  localparam int PIPE_W   = 52;
  localparam int BIRD_X   = 160;

  logic       clk = 1'b0;
  logic       rst, tick, run, clear;
  logic [6:0] rand_in;
  logic [1:0] rd_idx;
  logic       rd_valid   [3];
  logic [9:0] rd_x       [3];
  logic [8:0] rd_gap     [3];
  logic       pass_pulse [3];
  logic [2:0] count      [3];
  logic       full       [3];

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;

  always #10 clk = ~clk;

  pipe_spawner u_a (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear), .rand_in(rand_in), .rd_idx(rd_idx),
    .rd_valid(rd_valid[0]), .rd_x(rd_x[0]), .rd_gap(rd_gap[0]), .pass_pulse(pass_pulse[0]),
    .count(count[0]), .full(full[0]));

  pipe_spawner #(.SPACING(40)) u_b (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear), .rand_in(rand_in), .rd_idx(rd_idx),
    .rd_valid(rd_valid[1]), .rd_x(rd_x[1]), .rd_gap(rd_gap[1]), .pass_pulse(pass_pulse[1]),
    .count(count[1]), .full(full[1]));

  pipe_spawner #(.SPACING(1)) u_c (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear), .rand_in(rand_in), .rd_idx(rd_idx),
    .rd_valid(rd_valid[2]), .rd_x(rd_x[2]), .rd_gap(rd_gap[2]), .pass_pulse(pass_pulse[2]),
    .count(count[2]), .full(full[2]));

  // Model: a list of 4 pipes per instance plus a "game mode" (0 idle, 1 running, 2 frozen).
  int m_valid [3][4];
  int m_x     [3][4];
  int m_gap   [3][4];
  int m_wr    [3];
  int m_wait  [3];
  int m_mode  [3];
  int m_pass  [3];

  function automatic int spacing_of(input int k);
    return (k == 0) ? 90 : (k == 1) ? 40 : 1;
  endfunction

  function automatic int live(input int k);
    int n = 0;
    for (int i = 0; i < 4; i++) n += m_valid[k][i];
    return n;
  endfunction

  task automatic model_step();
    int nx;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) begin m_valid[k][i] = 0; m_x[k][i] = 0; m_gap[k][i] = 0; end
        m_wr[k] = 0; m_wait[k] = 0; m_mode[k] = 0; m_pass[k] = 0;
      end else if (clear) begin
        for (int i = 0; i < 4; i++) m_valid[k][i] = 0;
        m_wr[k] = 0; m_wait[k] = 0; m_mode[k] = 0; m_pass[k] = 0;
      end else begin
        m_pass[k] = 0;
        if (tick && m_mode[k] == 1) begin
          for (int i = 0; i < 4; i++) begin
            if (m_valid[k][i] != 0) begin
              if (m_x[k][i] < SPEED) m_valid[k][i] = 0;
              else begin
                nx = m_x[k][i] - SPEED;
                if (m_x[k][i] + PIPE_W > BIRD_X && nx + PIPE_W <= BIRD_X) m_pass[k] = 1;
                m_x[k][i] = nx;
              end
            end
          end
          if (m_wait[k] == 0) begin
            m_wait[k] = spacing_of(k) - 1;
            if (m_valid[k][m_wr[k]] == 0) begin
              m_valid[k][m_wr[k]] = 1;
              m_x[k][m_wr[k]]     = SCREEN_W;
              m_gap[k][m_wr[k]]   = GAP_MIN + int'(rand_in);
              m_wr[k]             = (m_wr[k] + 1) % 4;
            end
          end else begin
            m_wait[k] = m_wait[k] - 1;
          end
        end
        if (m_mode[k] == 0 && run) begin m_mode[k] = 1; m_wait[k] = 0; end
        else if (m_mode[k] == 1 && !run) m_mode[k] = 2;
        else if (m_mode[k] == 2 && run) m_mode[k] = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Compare every cycle on the falling edge, sweeping the read port over all slots.
  initial begin
    rd_idx = 2'd0;
    forever begin
      @(negedge clk);
      if (started) begin
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("count[%0d]", k), int'(count[k]), live(k));
          chk($sformatf("full[%0d]", k), int'(full[k]), (live(k) == 4) ? 1 : 0);
          chk($sformatf("pass_pulse[%0d]", k), int'(pass_pulse[k]), m_pass[k]);
        end
        for (int i = 0; i < 4; i++) begin
          rd_idx = 2'(i);
          #1;
          for (int k = 0; k < 3; k++) begin
            chk($sformatf("rd_valid[%0d] slot%0d", k, i), int'(rd_valid[k]), m_valid[k][i]);
            chk($sformatf("rd_x[%0d] slot%0d", k, i), int'(rd_x[k]), m_x[k][i]);
            chk($sformatf("rd_gap[%0d] slot%0d", k, i), int'(rd_gap[k]), m_gap[k][i]);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic tick_once(input logic [6:0] r);
    tick = 1'b1;
    rand_in = r;
    @(posedge clk); #1;
    tick = 1'b0;
    rand_in = 7'($urandom);
  endtask

  initial begin
    logic [6:0] r;
    int saved_x [4];
    rst = 1'b1; tick = 1'b0; run = 1'b0; clear = 1'b0; rand_in = 7'd0;
    idle(1);
    started = 1;
    idle(2);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset count[%0d]", k), int'(count[k]), 0);
      chk($sformatf("reset full[%0d]", k), int'(full[k]), 0);
      chk($sformatf("reset pass[%0d]", k), int'(pass_pulse[k]), 0);
    end

    rst = 1'b0; run = 1'b1;
    idle(1);
    tick_once(7'h05);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("first spawn valid[%0d]", k), m_valid[k][0], 1);
      chk($sformatf("first spawn x[%0d]", k), m_x[k][0], 640);
      chk($sformatf("first spawn gap[%0d]", k), m_gap[k][0], 85);
      chk($sformatf("first spawn count[%0d]", k), int'(count[k]), 1);
    end

    for (int t = 1; t <= 400; t++) begin
      idle($urandom_range(1, 2));
      r = 7'($urandom);
      tick_once(r);
      if (t == 3)   chk("spacing1 count after 4 spawns", int'(count[2]), 4);
      if (t == 10)  chk("x after 10 ticks", m_x[0][0], 620);
      if (t == 120) begin
        chk("spacing40 count", int'(count[1]), 4);
        chk("spacing40 full", int'(full[1]), 1);
      end
      if (t == 160) begin
        chk("drop keeps wr_ptr", m_wr[1], 0);
        chk("drop keeps slot0 x", m_x[1][0], 320);
        chk("drop keeps slot0 gap", m_gap[1][0], 85);
      end
      if (t == 265) begin
        chk("x before pass", m_x[0][0], 110);
        chk("no pass before", m_pass[0], 0);
      end
      if (t == 266) begin
        chk("x at pass", m_x[0][0], 108);
        chk("pass tick", m_pass[0], 1);
        chk("pass pulse dut", int'(pass_pulse[0]), 1);
      end
      if (t == 267) chk("no pass after", m_pass[0], 0);
      if (t == 320) begin
        chk("x at left edge", m_x[0][0], 0);
        chk("valid at left edge", m_valid[0][0], 1);
        chk("count before retire", int'(count[0]), 4);
        chk("spacing40 full before retire", int'(full[1]), 1);
      end
      if (t == 321) begin
        chk("retired valid", m_valid[0][0], 0);
        chk("count after retire", int'(count[0]), 3);
        chk("spacing40 full after retire", int'(full[1]), 0);
        chk("refill x", m_x[2][0], 640);
        chk("refill gap", m_gap[2][0], GAP_MIN + int'(r));
        chk("refill count", int'(count[2]), 4);
      end
      if (t == 360) chk("spacing40 slot0 respawn", m_x[1][0], 640);
    end

    // Run drop on the same edge as a tick: tick honoured, then frozen.
    idle(1);
    run = 1'b0;
    tick_once(7'($urandom));
    for (int i = 0; i < 4; i++) saved_x[i] = m_x[0][i];
    for (int n = 0; n < 20; n++) begin idle(1); tick_once(7'($urandom)); end
    for (int i = 0; i < 4; i++) chk($sformatf("frozen x slot%0d", i), m_x[0][i], saved_x[i]);
    chk("frozen mode", m_mode[0], 2);

    clear = 1'b1; tick = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; tick = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("clear count[%0d]", k), int'(count[k]), 0);
      chk($sformatf("clear pass[%0d]", k), int'(pass_pulse[k]), 0);
    end
    idle(2);
    run = 1'b1;
    idle(1);
    tick_once(7'h7f);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("restart x[%0d]", k), m_x[k][0], 640);
      chk($sformatf("restart gap[%0d]", k), m_gap[k][0], 207);
      chk($sformatf("restart count[%0d]", k), int'(count[k]), 1);
    end

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) run = ~run;
      clear   = ($urandom_range(0, 99) == 0);
      tick    = ($urandom_range(0, 2) == 0);
      rand_in = 7'($urandom);
      rst     = (c == 1500);
      @(posedge clk); #1;
      if (c == 1500) chk("mid-run reset count", int'(count[0]), 0);
    end
    rst = 1'b0; clear = 1'b0; tick = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
